// File: rtl/output_port_tx.sv
// Purpose: transmit side of one mesh-router output port. Arbitrates five sources round-robin
//          per packet, buffers flits in a small FIFO and sends them downstream against credits.
// Latency: a flit accepted on edge N is driven on flit_out_o after edge N+1 at the earliest.
// Backpressure: grant_o drops while the FIFO is full or enable_i=0; sends stall while credits are 0.
//
// Ports:
//   clk_i         clock, rising edge
//   reset_n_i     asynchronous active-low reset
//   enable_i      1 = operate, 0 = freeze (no grants, no sends; credits still counted)
//   req_i[4:0]    per-source flit valid (0 ip, 1 north, 2 south, 3 east, 4 west)
//   flit_bus_i    five 32-bit flits, source k on [32k+31:32k]
//   grant_o[4:0]  one-hot combinational accept; flit k taken on the edge where req_i[k]&grant_o[k]
//   flit_out_o    registered flit to the downstream input port
//   flit_valid_o  one-cycle pulse per flit sent
//   credit_in_i   one-cycle pulse: downstream freed one slot
//   error_o       sticky protocol-error flag
module output_port_tx #(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 5
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         enable_i,
    input  logic [4:0]   req_i,
    input  logic [159:0] flit_bus_i,
    output logic [4:0]   grant_o,
    output logic [31:0]  flit_out_o,
    output logic         flit_valid_o,
    input  logic         credit_in_i,
    output logic         error_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [CW-1:0] credit_q;
    state_e        state_q;
    logic [2:0]    owner_q;
    logic [2:0]    rr_q;
    logic [31:0]   flit_out_q;
    logic          flit_valid_q;
    logic          error_q;

    logic          full, empty, send, accept, err_set;
    logic [4:0]    grant_d;
    logic          head_found, bad_idle;
    logic [2:0]    head_idx, acc_idx;
    logic [31:0]   acc_flit;
    int            ptr;

    // Full/empty come from the registered count, so a same-cycle pop never opens a grant.
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign send  = enable_i && !empty && (credit_q != '0);

    always_comb begin
        grant_d    = '0;
        head_found = 1'b0;
        head_idx   = '0;
        bad_idle   = 1'b0;
        ptr        = 0;
        // Round-robin search for a head flit starting at rr_q, wrapping 4 -> 0.
        for (int i = 0; i < 5; i++) begin
            ptr = int'(rr_q) + i;
            if (ptr >= 5) ptr = ptr - 5;
            if (!head_found && req_i[ptr] && flit_bus_i[32*ptr+30 +: 2] == FT_HEAD) begin
                head_found = 1'b1;
                head_idx   = 3'(ptr);
            end
            // Body and tail both have bit 31 set; either one is illegal with no packet open.
            if (req_i[i] && flit_bus_i[32*i+31]) bad_idle = 1'b1;
        end
        if (reset_n_i && enable_i && !full) begin
            if (state_q == ST_IDLE) begin
                if (head_found) grant_d[head_idx] = 1'b1;
            end else begin
                grant_d[owner_q] = req_i[owner_q];
            end
        end
    end

    always_comb begin
        acc_idx  = '0;
        acc_flit = '0;
        for (int k = 0; k < 5; k++) begin
            if (grant_d[k]) begin
                acc_idx  = 3'(k);
                acc_flit = flit_bus_i[32*k +: 32];
            end
        end
    end

    // Grants are only ever issued to requesting sources.
    assign accept = |grant_d;

    assign err_set = (enable_i && state_q == ST_IDLE && bad_idle)
                   || (accept && state_q == ST_LOCKED && acc_flit[31:30] == FT_HEAD)
                   || (credit_in_i && !send && credit_q == CW'(CREDITS));

    always_ff @(posedge clk_i) begin
        if (accept) mem_q[wr_ptr_q] <= acc_flit;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flit_out_q   <= '0;
            flit_valid_q <= 1'b0;
        end else begin
            if (send) begin
                flit_out_q   <= mem_q[rd_ptr_q];
                flit_valid_q <= 1'b1;
                rd_ptr_q     <= rd_ptr_q + 1'b1;
            end else begin
                flit_valid_q <= 1'b0;
            end
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (accept && !send)      count_q <= count_q + 1'b1;
            else if (!accept && send) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credit_q <= CW'(CREDITS);
        end else begin
            // A return at the ceiling saturates; the error flag records it.
            if (send && !credit_in_i)
                credit_q <= credit_q - 1'b1;
            else if (!send && credit_in_i && credit_q != CW'(CREDITS))
                credit_q <= credit_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_LOCKED;
                    owner_q <= acc_idx;
                end
                ST_LOCKED: begin
                    if (acc_flit[31:30] == FT_TAIL) begin
                        state_q <= ST_IDLE;
                        rr_q    <= (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) error_q <= 1'b0;
        else if (err_set) error_q <= 1'b1;
    end

    assign grant_o      = grant_d;
    assign flit_out_o   = flit_out_q;
    assign flit_valid_o = flit_valid_q;
    assign error_o      = error_q;
endmodule

// File: tb/tb_output_port_tx.sv
// Purpose: self-checking bench for output_port_tx with a queue-based reference model.
// Latency: checks grant/valid/error every cycle; sent flits are matched by a separate monitor.
// Backpressure: the bench returns credits randomly and only while the downstream has outstanding flits.
module tb_output_port_tx;
    localparam int DEPTH   = 4;
    localparam int CREDITS = 5;

    logic         clk = 1'b0;
    logic         reset_n, enable, credit_in;
    logic [4:0]   req;
    logic [159:0] flit_bus;
    logic [4:0]   grant;
    logic [31:0]  flit_out;
    logic         flit_valid, error;

    always #5 clk = ~clk;

    output_port_tx #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .req_i(req),
        .flit_bus_i(flit_bus), .grant_o(grant), .flit_out_o(flit_out),
        .flit_valid_o(flit_valid), .credit_in_i(credit_in), .error_o(error)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: per-source pending flits, output FIFO contents, expected output stream.
    logic [31:0] src_q [5][$];
    logic [31:0] m_fifo[$];
    logic [31:0] exp_out[$];
    bit          m_locked, m_err, m_vld;
    int          m_owner, m_rr, m_cred;

    int req_pct, cred_pct;
    bit en_drv, force_cin;
    int n_seen, n_gnt0, n_busy;
    logic [4:0] first_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ty(input logic [31:0] f);
        return f[31:30];
    endfunction

    function automatic logic [4:0] exp_grant();
        if (!enable || m_fifo.size() == DEPTH) return 5'b0;
        if (!m_locked) begin
            for (int i = 0; i < 5; i++) begin
                int k = (m_rr + i) % 5;
                if (req[k] && ty(flit_bus[32*k +: 32]) == 2'b01) return 5'(1 << k);
            end
            return 5'b0;
        end
        return req[m_owner] ? 5'(1 << m_owner) : 5'b0;
    endfunction

    task automatic model_step(input logic [4:0] g);
        bit snd;
        int k;
        logic [31:0] f;
        if (enable && !m_locked)
            for (int i = 0; i < 5; i++)
                if (req[i] && (ty(flit_bus[32*i +: 32]) == 2'b10 || ty(flit_bus[32*i +: 32]) == 2'b11))
                    m_err = 1'b1;
        snd = enable && m_fifo.size() > 0 && m_cred > 0;
        if (snd) exp_out.push_back(m_fifo.pop_front());
        m_vld = snd;
        if (credit_in && !snd) begin
            if (m_cred == CREDITS) m_err = 1'b1;
            else m_cred++;
        end else if (snd && !credit_in) begin
            m_cred--;
        end
        if (g != 5'b0) begin
            k = 0;
            for (int i = 0; i < 5; i++) if (g[i]) k = i;
            f = flit_bus[32*k +: 32];
            m_fifo.push_back(f);
            void'(src_q[k].pop_front());
            if (!m_locked) begin
                m_locked = 1'b1;
                m_owner  = k;
            end else if (ty(f) == 2'b11) begin
                m_locked = 1'b0;
                m_rr     = (m_owner + 1) % 5;
            end else if (ty(f) == 2'b01) begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 5; k++) begin
            if (src_q[k].size() > 0 && $urandom_range(99) < req_pct) begin
                req[k] = 1'b1;
                flit_bus[32*k +: 32] = src_q[k][0];
            end else begin
                req[k] = 1'b0;
                flit_bus[32*k +: 32] = $urandom;
            end
        end
        credit_in = force_cin || (m_cred < CREDITS && $urandom_range(99) < cred_pct);
        enable = en_drv;
    endtask

    task automatic cycle();
        logic [4:0] g;
        @(negedge clk);
        g = exp_grant();
        chk("grant", 32'(grant), 32'(g));
        chk("flit_valid", 32'(flit_valid), 32'(m_vld));
        chk("error", 32'(error), 32'(m_err));
        if (grant[0]) n_gnt0++;
        if (grant != 5'b0) n_busy++;
        if (grant != 5'b0 && first_g == 5'b0) first_g = grant;
        model_step(g);
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic load_pkt(input int k, input int nbody);
        src_q[k].push_back({2'b01, 30'($urandom)});
        for (int i = 0; i < nbody; i++) src_q[k].push_back({2'b10, 30'($urandom)});
        src_q[k].push_back({2'b11, 30'($urandom)});
    endtask

    task automatic model_clear();
        m_fifo.delete();
        exp_out.delete();
        for (int k = 0; k < 5; k++) src_q[k].delete();
        m_locked = 1'b0; m_owner = 0; m_rr = 0;
        m_cred = CREDITS; m_err = 1'b0; m_vld = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_flit_out", flit_out, 32'h0);
        chk("rst_flit_valid", 32'(flit_valid), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        model_clear();
        force_cin = 1'b0;
        req = '0;
        credit_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive();
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && flit_valid === 1'b1) begin
            n_seen++;
            if (exp_out.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_unexpected_flit: got %0h expected none", flit_out);
            end else begin
                chk("mon_flit_out", flit_out, exp_out.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        reset_n = 1'b0; enable = 1'b0; req = '0; flit_bus = '0; credit_in = 1'b0;
        en_drv = 1'b1; force_cin = 1'b0; req_pct = 100; cred_pct = 0;
        n_seen = 0; n_gnt0 = 0; n_busy = 0; first_g = '0;
        model_clear();
        #3;
        chk("init_grant", 32'(grant), 32'h0);
        chk("init_flit_out", flit_out, 32'h0);
        chk("init_flit_valid", 32'(flit_valid), 32'h0);
        chk("init_error", 32'(error), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: ip sends head, body, tail back to back; no credit return.
        load_pkt(0, 1);
        drive();
        s = n_seen; n_gnt0 = 0;
        repeat (8) cycle();
        chk("s1_pulses", 32'(n_seen - s), 32'd3);
        chk("s1_gnt0_cycles", 32'(n_gnt0), 32'd3);
        cred_pct = 100;
        repeat (4) cycle();

        // 2: north and east both offer heads with rr at 0.
        do_reset();
        req_pct = 100; cred_pct = 100;
        load_pkt(1, 2); load_pkt(3, 1);
        drive();
        first_g = '0; s = n_seen;
        repeat (14) cycle();
        chk("s2_first_grant", 32'(first_g), 32'h2);
        chk("s2_flits_sent", 32'(n_seen - s), 32'd7);

        // 3: ten-flit packet with no credit return; FIFO fills, then credits trickle in.
        do_reset();
        cred_pct = 0;
        load_pkt(2, 8);
        drive();
        s = n_seen;
        repeat (14) cycle();
        chk("s3_sent_on_credits", 32'(n_seen - s), 32'd5);
        chk("s3_grant_when_full", 32'(grant), 32'h0);
        for (int p = 0; p < 3; p++) begin
            s = n_seen;
            force_cin = 1'b1; drive(); force_cin = 1'b0;
            repeat (3) cycle();
            chk("s3_one_flit_per_credit", 32'(n_seen - s), 32'd1);
        end
        cred_pct = 100;
        repeat (12) cycle();

        // 4: body offered in IDLE, then a credit beyond the maximum.
        do_reset();
        src_q[0].push_back({2'b10, 30'($urandom)});
        drive();
        repeat (3) cycle();
        chk("s4_body_idle_error", 32'(error), 32'h1);
        src_q[0].delete();
        drive();
        repeat (3) cycle();
        chk("s4_error_sticky", 32'(error), 32'h1);
        do_reset();
        force_cin = 1'b1; drive(); force_cin = 1'b0;
        repeat (2) cycle();
        chk("s4_credit_overflow_error", 32'(error), 32'h1);

        // 5: reset with three flits parked in the FIFO, then a fresh packet uses all 5 credits.
        do_reset();
        cred_pct = 0;
        load_pkt(4, 6);
        drive();
        repeat (8) cycle();
        do_reset();
        load_pkt(int'($urandom_range(4)), 3);
        drive();
        s = n_seen;
        repeat (9) cycle();
        chk("s5_fresh_packet_sent", 32'(n_seen - s), 32'd5);
        cred_pct = 100;
        repeat (4) cycle();

        // 6: enable low for three cycles mid-stream.
        do_reset();
        req_pct = 100; cred_pct = 100;
        load_pkt(0, 5); load_pkt(2, 2);
        drive();
        repeat (4) cycle();
        en_drv = 1'b0; drive();
        n_busy = 0;
        repeat (2) cycle();
        en_drv = 1'b1;
        cycle();
        chk("s6_no_grant_disabled", 32'(n_busy), 32'd0);
        repeat (20) cycle();
        chk("s6_stream_resumed", 32'(exp_out.size() + m_fifo.size()), 32'd0);

        // Random traffic from all sources.
        do_reset();
        req_pct = 70; cred_pct = 50;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 5; k++)
                if (src_q[k].size() == 0 && $urandom_range(9) == 0)
                    load_pkt(k, int'($urandom_range(4)));
            en_drv = ($urandom_range(19) != 0);
            cycle();
        end
        en_drv = 1'b1; req_pct = 100; cred_pct = 100;
        repeat (80) cycle();
        chk("drain_all_flits_delivered", 32'(exp_out.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
